// File: rtl/gpio_input_port.sv
// gpio_input_port
// Memory-mapped GPIO input block: per-pin two-flop synchronizer, optional
// debounce, sticky rising-edge register (write-1-to-clear), IRQ mask and a
// registered level interrupt. Register map:
//   ADDR_IN   - debounced pin levels (read-only)
//   ADDR_EDGE - sticky rising-edge flags, write 1 to clear
//   ADDR_MASK - interrupt enable per pin
// Compile-time option: define GPIO_IN_DEBOUNCE_EN to insert a per-pin
// 8-bit stability counter between the synchronizer and db. Without it, db
// simply re-registers the synchronizer output.
// Reset is synchronous and active-low on rst.

module gpio_input_port #(
    parameter int                   BIT_WIDTH       = 32,
    parameter int                   PORT_WIDTH      = 8,
    parameter int                   DEBOUNCE_CYCLES = 4,
    parameter logic [BIT_WIDTH-1:0] ADDR_IN         = 32'h10010028,
    parameter logic [BIT_WIDTH-1:0] ADDR_EDGE       = 32'h1001002C,
    parameter logic [BIT_WIDTH-1:0] ADDR_MASK       = 32'h10010030
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BIT_WIDTH-1:0]  Address,
    input  logic [BIT_WIDTH-1:0]  Data,
    input  logic                  MemWrite,
    input  logic [PORT_WIDTH-1:0] GPIO_PORT_IN,
    output logic [BIT_WIDTH-1:0]  ReadData,
    output logic                  Irq
);

    logic [PORT_WIDTH-1:0] s1;
    logic [PORT_WIDTH-1:0] s2;
    logic [PORT_WIDTH-1:0] db;
    logic [PORT_WIDTH-1:0] db_d;
    logic [PORT_WIDTH-1:0] edge_reg;
    logic [PORT_WIDTH-1:0] edge_next;
    logic [PORT_WIDTH-1:0] irq_mask;
    logic [PORT_WIDTH-1:0] rise;
    logic [PORT_WIDTH-1:0] clr;
    logic [PORT_WIDTH-1:0] wr_bits;
    logic                  wr_edge;
    logic                  wr_mask;

    assign wr_bits = Data[PORT_WIDTH-1:0];
    assign wr_edge = MemWrite && (Address == ADDR_EDGE);
    assign wr_mask = MemWrite && (Address == ADDR_MASK);

    // Upper data bits are never stored; tie them off so they are visibly unused.
    generate
        if (PORT_WIDTH < BIT_WIDTH) begin : g_unused_data
            logic unused_data;
            assign unused_data = ^Data[BIT_WIDTH-1:PORT_WIDTH];
        end
    endgenerate

    // Two-flop synchronizer on the asynchronous pins.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= GPIO_PORT_IN;
            s2 <= s1;
        end
    end

`ifdef GPIO_IN_DEBOUNCE_EN
    // db only moves after DEBOUNCE_CYCLES consecutive cycles of disagreement.
    localparam logic [7:0] DB_TC = 8'(DEBOUNCE_CYCLES - 1);

    logic [7:0] db_cnt [PORT_WIDTH];

    // Per-pin stability counter; any cycle of agreement restarts the count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            db <= '0;
            for (int i = 0; i < PORT_WIDTH; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < PORT_WIDTH; i++) begin
                if (s2[i] != db[i]) begin
                    if (db_cnt[i] == DB_TC) begin
                        db[i]     <= s2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 8'd1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end
`else
    // No debounce: db is a plain third stage behind the synchronizer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            db <= '0;
        end else begin
            db <= s2;
        end
    end
`endif

    // A rise is seen the cycle after db goes high, so the flag lands one edge later.
    assign rise = db & ~db_d;
    assign clr  = wr_edge ? wr_bits : '0;

    // Clear first, then OR in new rises so a same-cycle rise is never lost.
    always_comb begin
        edge_next = (edge_reg & ~clr) | rise;
    end

    // Edge history, sticky flags, mask and interrupt level.
    always_ff @(posedge clk) begin
        if (!rst) begin
            db_d     <= '0;
            edge_reg <= '0;
            irq_mask <= '0;
            Irq      <= 1'b0;
        end else begin
            db_d     <= db;
            edge_reg <= edge_next;
            if (wr_mask) begin
                irq_mask <= wr_bits;
            end
            Irq <= |(edge_reg & irq_mask);
        end
    end

    // Read mux; unmapped addresses return zero and reads never alter state.
    always_comb begin
        ReadData = '0;
        if (Address == ADDR_IN) begin
            ReadData[PORT_WIDTH-1:0] = db;
        end else if (Address == ADDR_EDGE) begin
            ReadData[PORT_WIDTH-1:0] = edge_reg;
        end else if (Address == ADDR_MASK) begin
            ReadData[PORT_WIDTH-1:0] = irq_mask;
        end
    end

endmodule

// File: tb/tb_gpio_input_port.sv
// Directed bench for gpio_input_port. Latency expectations follow the
// GPIO_IN_DEBOUNCE_EN build option (2+N edges with debounce, 3 without).

module tb_gpio_input_port;

    localparam int N = 4;
`ifdef GPIO_IN_DEBOUNCE_EN
    localparam int LAT   = 2 + N;
    localparam bit DB_ON = 1'b1;
`else
    localparam int LAT   = 3;
    localparam bit DB_ON = 1'b0;
`endif

    localparam logic [31:0] A_IN   = 32'h10010028;
    localparam logic [31:0] A_EDGE = 32'h1001002C;
    localparam logic [31:0] A_MASK = 32'h10010030;
    localparam logic [31:0] A_NONE = 32'h10010024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] Address = 32'h0;
    logic [31:0] Data = 32'h0;
    logic        MemWrite = 1'b0;
    logic [7:0]  GPIO_PORT_IN = 8'h00;
    logic [31:0] ReadData;
    logic        Irq;

    int total = 0;
    int bad   = 0;

    gpio_input_port #(
        .BIT_WIDTH(32),
        .PORT_WIDTH(8),
        .DEBOUNCE_CYCLES(N)
    ) dut (
        .clk(clk),
        .rst(rst),
        .Address(Address),
        .Data(Data),
        .MemWrite(MemWrite),
        .GPIO_PORT_IN(GPIO_PORT_IN),
        .ReadData(ReadData),
        .Irq(Irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        Address = a;
        #1;
        d = ReadData;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        Address  = a;
        Data     = d;
        MemWrite = 1'b1;
        tick(1);
        MemWrite = 1'b0;
        Data     = 32'h0;
        Address  = 32'h0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b0;
        GPIO_PORT_IN = 8'h00;
        tick(2);
        rd(A_IN, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_in got=%h exp=%h", d, 32'h0); end
        rd(A_EDGE, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_edge got=%h exp=%h", d, 32'h0); end
        rd(A_MASK, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_mask got=%h exp=%h", d, 32'h0); end
        total++; if (Irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", Irq); end
        rst = 1'b1;
        tick(2);
    endtask

    task automatic test_rising();
        logic [31:0] d;
        GPIO_PORT_IN = 8'h05;
        tick(LAT - 1);
        rd(A_IN, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL in_early got=%h exp=%h", d, 32'h0); end
        tick(1);
        rd(A_IN, d);
        total++; if (d !== 32'h5) begin bad++; $display("FAIL in_latency got=%h exp=%h", d, 32'h5); end
        rd(A_EDGE, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL edge_early got=%h exp=%h", d, 32'h0); end
        tick(1);
        rd(A_EDGE, d);
        total++; if (d !== 32'h5) begin bad++; $display("FAIL edge_set got=%h exp=%h", d, 32'h5); end
        total++; if (Irq !== 1'b0) begin bad++; $display("FAIL irq_masked got=%b exp=0", Irq); end
    endtask

    task automatic test_glitch();
        logic [31:0] d;
        logic        seen;
        logic [31:0] exp_edge;
        seen = 1'b0;
        GPIO_PORT_IN = 8'h85;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            rd(A_IN, d);
            seen = seen | d[7];
        end
        GPIO_PORT_IN = 8'h05;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            rd(A_IN, d);
            seen = seen | d[7];
        end
        total++; if (seen !== !DB_ON) begin bad++; $display("FAIL glitch_db7 got=%b exp=%b", seen, !DB_ON); end
        exp_edge = DB_ON ? 32'h05 : 32'h85;
        rd(A_EDGE, d);
        total++; if (d !== exp_edge) begin bad++; $display("FAIL glitch_edge got=%h exp=%h", d, exp_edge); end
        wr(A_EDGE, 32'h80);
        rd(A_EDGE, d);
        total++; if (d !== 32'h05) begin bad++; $display("FAIL w1c_bit7 got=%h exp=%h", d, 32'h05); end
    endtask

    task automatic test_w1c();
        logic [31:0] d;
        wr(A_EDGE, 32'h01);
        rd(A_EDGE, d);
        total++; if (d !== 32'h04) begin bad++; $display("FAIL w1c_bit0 got=%h exp=%h", d, 32'h04); end
        GPIO_PORT_IN = 8'h04;
        tick(LAT + 2);
        rd(A_IN, d);
        total++; if (d !== 32'h04) begin bad++; $display("FAIL in_fall got=%h exp=%h", d, 32'h04); end
        rd(A_EDGE, d);
        total++; if (d !== 32'h04) begin bad++; $display("FAIL edge_fall got=%h exp=%h", d, 32'h04); end
        GPIO_PORT_IN = 8'h05;
        tick(LAT);
        rd(A_IN, d);
        total++; if (d !== 32'h05) begin bad++; $display("FAIL in_rerise got=%h exp=%h", d, 32'h05); end
        wr(A_EDGE, 32'h01);
        rd(A_EDGE, d);
        total++; if (d !== 32'h05) begin bad++; $display("FAIL set_wins got=%h exp=%h", d, 32'h05); end
    endtask

    task automatic test_irq();
        logic [31:0] d;
        wr(A_MASK, 32'h04);
        total++; if (Irq !== 1'b0) begin bad++; $display("FAIL irq_delay got=%b exp=0", Irq); end
        rd(A_MASK, d);
        total++; if (d !== 32'h04) begin bad++; $display("FAIL mask_rd got=%h exp=%h", d, 32'h04); end
        tick(1);
        total++; if (Irq !== 1'b1) begin bad++; $display("FAIL irq_set got=%b exp=1", Irq); end
        wr(A_EDGE, 32'h04);
        rd(A_EDGE, d);
        total++; if (d !== 32'h01) begin bad++; $display("FAIL edge_clr2 got=%h exp=%h", d, 32'h01); end
        total++; if (Irq !== 1'b1) begin bad++; $display("FAIL irq_hold got=%b exp=1", Irq); end
        tick(1);
        total++; if (Irq !== 1'b0) begin bad++; $display("FAIL irq_clr got=%b exp=0", Irq); end
        wr(A_MASK, 32'hFFFF_FF02);
        rd(A_MASK, d);
        total++; if (d !== 32'h02) begin bad++; $display("FAIL mask_trunc got=%h exp=%h", d, 32'h02); end
        tick(2);
        total++; if (Irq !== 1'b0) begin bad++; $display("FAIL irq_nomatch got=%b exp=0", Irq); end
    endtask

    task automatic test_unmapped();
        logic [31:0] d;
        wr(A_IN, 32'hFF);
        wr(A_NONE, 32'hFF);
        tick(1);
        rd(A_IN, d);
        total++; if (d !== 32'h05) begin bad++; $display("FAIL ro_in got=%h exp=%h", d, 32'h05); end
        rd(A_EDGE, d);
        total++; if (d !== 32'h01) begin bad++; $display("FAIL ro_edge got=%h exp=%h", d, 32'h01); end
        rd(A_MASK, d);
        total++; if (d !== 32'h02) begin bad++; $display("FAIL ro_mask got=%h exp=%h", d, 32'h02); end
        rd(A_NONE, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL unmapped_rd got=%h exp=%h", d, 32'h0); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        GPIO_PORT_IN = 8'h35;
        tick(LAT - 2);
        Address  = A_MASK;
        Data     = 32'hFF;
        MemWrite = 1'b1;
        rst      = 1'b0;
        tick(1);
        MemWrite = 1'b0;
        Data     = 32'h0;
        rd(A_IN, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL mid_in got=%h exp=%h", d, 32'h0); end
        rd(A_EDGE, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL mid_edge got=%h exp=%h", d, 32'h0); end
        rd(A_MASK, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL mid_mask got=%h exp=%h", d, 32'h0); end
        total++; if (Irq !== 1'b0) begin bad++; $display("FAIL mid_irq got=%b exp=0", Irq); end
        rst = 1'b1;
        tick(LAT - 1);
        rd(A_IN, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL post_early got=%h exp=%h", d, 32'h0); end
        tick(1);
        rd(A_IN, d);
        total++; if (d !== 32'h35) begin bad++; $display("FAIL post_in got=%h exp=%h", d, 32'h35); end
        tick(1);
        rd(A_EDGE, d);
        total++; if (d !== 32'h35) begin bad++; $display("FAIL post_edge got=%h exp=%h", d, 32'h35); end
        wr(A_MASK, 32'h10);
        tick(1);
        total++; if (Irq !== 1'b1) begin bad++; $display("FAIL post_irq got=%b exp=1", Irq); end
    endtask

    initial begin
        test_reset();
        test_rising();
        test_glitch();
        test_w1c();
        test_irq();
        test_unmapped();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpio_input_port.md
GPIO_INPUT_PORT -- requirements
Module: gpio_input_port

Interface
REQ-001 Parameter BIT_WIDTH, default 32: width of the CPU address and data buses.
REQ-002 Parameter PORT_WIDTH, default 8: number of GPIO input pins; legal range 1..32.
REQ-003 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles required before a bit changes; legal range 1..255.
REQ-004 Parameter ADDR_IN, default 32'h10010028: address of the read-only GPIO_IN register.
REQ-005 Parameter ADDR_EDGE, default 32'h1001002C: address of the sticky EDGE register; write-1-to-clear.
REQ-006 Parameter ADDR_MASK, default 32'h10010030: address of the read/write IRQ_MASK register.
REQ-007 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-008 Port rst, input, 1: reset, synchronous, active-low.
REQ-009 Port Address, input, BIT_WIDTH: CPU byte address.
REQ-010 Port Data, input, BIT_WIDTH: CPU write data.
REQ-011 Port MemWrite, input, 1: write strobe, qualified by Address.
REQ-012 Port GPIO_PORT_IN, input, PORT_WIDTH: asynchronous external pins.
REQ-013 Port ReadData, output, BIT_WIDTH: read data for the CPU memory mux.
REQ-014 Port Irq, output, 1: level interrupt request.

Function
REQ-015 Each pin SHALL pass through a two-flop synchronizer (s1, s2) before any other use.
REQ-016 Debounced register db SHALL follow s2 as defined in REQ-029/REQ-030.
REQ-017 EDGE[i] SHALL be set on the clock edge after db[i] goes 0->1, and SHALL hold until cleared.
REQ-018 A write with Address==ADDR_EDGE SHALL clear every EDGE bit where Data[i]==1 and leave the other bits unchanged.
REQ-019 If a set and a clear of the same EDGE bit occur in the same cycle, the set SHALL win.
REQ-020 A write with Address==ADDR_MASK SHALL load IRQ_MASK from Data[PORT_WIDTH-1:0].
REQ-021 Writes to ADDR_IN or to any unmapped address SHALL have no effect.
REQ-022 Irq SHALL be registered: Irq <= |(EDGE & IRQ_MASK), one cycle after the operands change.
REQ-023 ReadData SHALL be combinational from Address: ADDR_IN->db, ADDR_EDGE->EDGE, ADDR_MASK->IRQ_MASK, zero-extended to BIT_WIDTH; any other address returns 0.
REQ-024 Reads SHALL have no side effects.

Reset
REQ-025 When rst is low at a clock edge, s1, s2, db, EDGE, IRQ_MASK, all debounce counters and Irq SHALL become 0.
REQ-026 Reset SHALL override any concurrent write or edge event.
REQ-027 A pin held high through reset SHALL produce an EDGE set once it propagates after reset releases.

Configuration
REQ-028 Macro GPIO_IN_DEBOUNCE_EN SHALL select debounce logic at compile time.
REQ-029 With GPIO_IN_DEBOUNCE_EN defined:
- each bit has an 8-bit counter that increments each cycle s2[i]!=db[i] and clears when they are equal;
- db[i]<=s2[i] and the counter clears on the DEBOUNCE_CYCLES-th consecutive differing cycle;
- pin-to-db latency is 2+DEBOUNCE_CYCLES edges.
REQ-030 Without GPIO_IN_DEBOUNCE_EN: db<=s2 every cycle, no counters are instantiated, and pin-to-db latency is 3 edges.

Verification
REQ-031 Reset, then read ADDR_IN, ADDR_EDGE and ADDR_MASK -> each returns 32'h0 and Irq=0.
REQ-032 With debounce enabled (N=4), GPIO_PORT_IN 8'h00->8'h05 held -> ADDR_IN reads 32'h5 after edge 6, EDGE reads 32'h5 after edge 7; a 3-cycle glitch on bit 7 leaves db[7]=0.
REQ-033 With EDGE=8'h05, write 32'h01 to ADDR_EDGE -> EDGE reads 32'h04; a same-cycle new rising edge on bit 0 with the clear -> EDGE reads 32'h05.
REQ-034 Write IRQ_MASK=8'h04 with EDGE bit 2 set -> Irq=1 one cycle later; write 32'h04 to ADDR_EDGE -> Irq=0 one cycle after EDGE clears.
REQ-035 Write 32'hFF to ADDR_IN and to 32'h10010024 -> no register changes, and reads of those addresses return db and 0 respectively.
REQ-036 Assert rst mid-debounce (counter=2) -> all state is 0; after release, a held pin requires the full 2+N edges.
